// File: rtl/pipeline_pkg.sv
// pipeline_pkg: definitions shared by the hazard/stall sequencer and the main
// opcode decoder.
//   pipe_state_t  - sequencer states (RUN, MEM_WAIT, TRAP)
//   REG_IDX_W     - architectural register index width
//   OPC_*         - RV32I major opcodes, shared with the main decoder
package pipeline_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TRAP     = 2'd2
   } pipe_state_t;

   localparam int REG_IDX_W = 5;

   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC_JALR   = 7'b110_0111;
   localparam logic [6:0] OPC_OP     = 7'b011_0011;
   localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
   localparam logic [6:0] OPC_LUI    = 7'b011_0111;
   localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs, memory handshake and pipeline-register
// controls between the datapath and the pipeline_ctrl sequencer.
//   master - the sequencer (drives enables, flushes, dmem_req, mem_timeout)
//   slave  - the datapath / data memory side
// Build option PIPE_PERF_EN adds the CNT_W-wide stall_cnt / flush_cnt signals.
interface pipeline_ctrl_if
`ifdef PIPE_PERF_EN
   #(parameter int CNT_W = 32)
`endif
   ;
   import pipeline_pkg::*;

   logic [REG_IDX_W-1:0] IF_ID_rs1;
   logic [REG_IDX_W-1:0] IF_ID_rs2;
   logic [REG_IDX_W-1:0] ID_EX_rd;
   logic                 ID_EX_MemRead;
   logic                 EX_Redirect;
   logic                 EX_MEM_MemRead;
   logic                 EX_MEM_MemWrite;
   logic                 dmem_ready;

   logic                 dmem_req;
   logic                 PC_Write;
   logic                 IF_ID_Write;
   logic                 IF_ID_Flush;
   logic                 ID_EX_Flush;
   logic                 EX_MEM_Hold;
   logic                 MEM_WB_Bubble;
   logic                 mem_timeout;
`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0]     stall_cnt;
   logic [CNT_W-1:0]     flush_cnt;
`endif

   modport master (
      input  IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_MemRead, EX_Redirect,
             EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready,
`ifdef PIPE_PERF_EN
      output stall_cnt, flush_cnt,
`endif
      output dmem_req, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
             EX_MEM_Hold, MEM_WB_Bubble, mem_timeout
   );

   modport slave (
      output IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_MemRead, EX_Redirect,
             EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready,
`ifdef PIPE_PERF_EN
      input  stall_cnt, flush_cnt,
`endif
      input  dmem_req, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
             EX_MEM_Hold, MEM_WB_Bubble, mem_timeout
   );

endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: purely combinational load-use hazard comparator.
//   id_ex_mem_read - instruction in EX is a load
//   id_ex_rd       - its destination register
//   if_id_rs1/rs2  - source registers of the instruction in ID
//   load_use       - ID needs the load result that is not yet available
module load_use_detect
   import pipeline_pkg::*;
(
   input  logic                 id_ex_mem_read,
   input  logic [REG_IDX_W-1:0] id_ex_rd,
   input  logic [REG_IDX_W-1:0] if_id_rs1,
   input  logic [REG_IDX_W-1:0] if_id_rs2,
   output logic                 load_use
);

   // x0 is hardwired to zero, so a load targeting it never creates a hazard.
   assign load_use = id_ex_mem_read
                   & (id_ex_rd != '0)
                   & ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stall sequencer for the 5-stage RISC-V pipeline.
// Drives pipeline-register enables/flushes from load-use and EX redirects, and
// runs the data-memory request/ready handshake with a hang timeout.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; outputs take reset values while high
//   bus   - pipeline_ctrl_if.master (hazard inputs, dmem handshake, controls)
// Parameters: MEM_TIMEOUT (>=1) consecutive stalled cycles before TRAP;
// CNT_W counter width (only with PIPE_PERF_EN).
// Build option PIPE_PERF_EN: saturating stall_cnt / flush_cnt.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal flow; load-use and redirect rules apply
// MEM_WAIT | memory access outstanding, pipeline frozen until dmem_ready
// TRAP     | memory hung; fully frozen, dmem_req dropped, only reset exits
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
`ifdef PIPE_PERF_EN
 , parameter int CNT_W       = 32
`endif
)(
   input  logic           clk,
   input  logic           reset,
   pipeline_ctrl_if.master bus
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

   pipe_state_t       state;
   logic [WAIT_W-1:0] wait_cnt;

   logic mem_op;
   logic mem_stall;
   logic load_use;

   logic pc_write;
   logic if_id_write;
   logic if_id_flush;
   logic id_ex_flush;
   logic ex_mem_hold;
   logic mem_wb_bubble;
   logic dmem_req;
   logic mem_timeout;

   assign mem_op    = bus.EX_MEM_MemRead | bus.EX_MEM_MemWrite;
   assign mem_stall = mem_op & ~bus.dmem_ready;

   load_use_detect u_load_use (
      .id_ex_mem_read (bus.ID_EX_MemRead),
      .id_ex_rd       (bus.ID_EX_rd),
      .if_id_rs1      (bus.IF_ID_rs1),
      .if_id_rs2      (bus.IF_ID_rs2),
      .load_use       (load_use)
   );

   // Outputs are combinational so a stall or flush takes effect in the same
   // cycle the condition appears; reset is folded in so it acts without a clock.
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_hold   = 1'b0;
      mem_wb_bubble = 1'b0;
      dmem_req      = mem_op;
      mem_timeout   = 1'b0;
      if (reset) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         mem_wb_bubble = 1'b1;
         dmem_req      = 1'b0;
      end else if (state == TRAP) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         ex_mem_hold   = 1'b1;
         mem_wb_bubble = 1'b1;
         dmem_req      = 1'b0;
         mem_timeout   = 1'b1;
      end else if (mem_stall) begin
         // Freeze wins over redirect and load-use; both are re-evaluated once
         // memory releases the pipeline.
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         ex_mem_hold   = 1'b1;
         mem_wb_bubble = 1'b1;
      end else if (bus.EX_Redirect) begin
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
      end else if (load_use) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_flush   = 1'b1;
      end
   end

   // wait_cnt holds the number of stalled cycles already completed before the
   // current one, so TRAP starts right after the MEM_TIMEOUT-th stalled cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (mem_stall) begin
                  state    <= (MEM_TIMEOUT == 1) ? TRAP : MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (!mem_stall) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == LAST_WAIT) begin
                  state    <= TRAP;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            TRAP:    state <= TRAP;
            default: state <= RUN;
         endcase
      end
   end

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // During reset both counters are held at zero, so the outputs seen here
   // are always from non-reset cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_write && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (if_id_flush && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = stall_cnt;
   assign bus.flush_cnt = flush_cnt;
`endif

   assign bus.PC_Write      = pc_write;
   assign bus.IF_ID_Write   = if_id_write;
   assign bus.IF_ID_Flush   = if_id_flush;
   assign bus.ID_EX_Flush   = id_ex_flush;
   assign bus.EX_MEM_Hold   = ex_mem_hold;
   assign bus.MEM_WB_Bubble = mem_wb_bubble;
   assign bus.dmem_req      = dmem_req;
   assign bus.mem_timeout   = mem_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MEM_TIMEOUT=4. Outputs are packed as
// {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Hold,
//  MEM_WB_Bubble, dmem_req, mem_timeout}.
module tb_pipeline_ctrl;
   import pipeline_pkg::*;

   localparam logic [7:0] O_RST    = 8'b0011_0100;
   localparam logic [7:0] O_DEF    = 8'b1100_0000;
   localparam logic [7:0] O_LU     = 8'b0001_0000;
   localparam logic [7:0] O_REDIR  = 8'b1111_0000;
   localparam logic [7:0] O_FRZ    = 8'b0000_1110;
   localparam logic [7:0] O_MEMOK  = 8'b1100_0010;
   localparam logic [7:0] O_MEMRD  = 8'b1111_0010;
   localparam logic [7:0] O_TRAP   = 8'b0000_1101;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

`ifdef PIPE_PERF_EN
   pipeline_ctrl_if #(.CNT_W(32)) bus ();
`else
   pipeline_ctrl_if bus ();
`endif

   pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   logic [7:0] outs;
   assign outs = {bus.PC_Write, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Flush,
                  bus.EX_MEM_Hold, bus.MEM_WB_Bubble, bus.dmem_req, bus.mem_timeout};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then changed and
   // outputs are sampled mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      bus.IF_ID_rs1 = '0; bus.IF_ID_rs2 = '0; bus.ID_EX_rd = '0;
      bus.ID_EX_MemRead = 1'b0; bus.EX_Redirect = 1'b0;
      bus.EX_MEM_MemRead = 1'b0; bus.EX_MEM_MemWrite = 1'b0;
      bus.dmem_ready = 1'b0;
      #2 chk("reset_outputs", {24'd0, outs}, {24'd0, O_RST});
      tick(); tick();
      reset = 1'b0;
      #2 chk("idle_run", {24'd0, outs}, {24'd0, O_DEF});
`ifdef PIPE_PERF_EN
      chk("perf_stall_after_reset", bus.stall_cnt, 32'd0);
      chk("perf_flush_after_reset", bus.flush_cnt, 32'd0);
`endif

      // load-use on rs1, one cycle
      tick();
      bus.ID_EX_MemRead = 1'b1; bus.ID_EX_rd = 5'd5; bus.IF_ID_rs1 = 5'd5; bus.IF_ID_rs2 = 5'd7;
      #2 chk("load_use_rs1", {24'd0, outs}, {24'd0, O_LU});
      tick();
      bus.ID_EX_MemRead = 1'b0;
      #2 chk("load_use_cleared", {24'd0, outs}, {24'd0, O_DEF});

      // load-use on rs2
      tick();
      bus.ID_EX_MemRead = 1'b1; bus.ID_EX_rd = 5'd9; bus.IF_ID_rs1 = 5'd1; bus.IF_ID_rs2 = 5'd9;
      #2 chk("load_use_rs2", {24'd0, outs}, {24'd0, O_LU});

      // load to x0 never stalls
      tick();
      bus.ID_EX_rd = 5'd0; bus.IF_ID_rs1 = 5'd3; bus.IF_ID_rs2 = 5'd0;
      #2 chk("load_x0_no_stall", {24'd0, outs}, {24'd0, O_DEF});

      // redirect beats load-use
      tick();
      bus.ID_EX_rd = 5'd4; bus.IF_ID_rs1 = 5'd4; bus.EX_Redirect = 1'b1;
      #2 chk("redirect_over_load_use", {24'd0, outs}, {24'd0, O_REDIR});
      tick();
      bus.ID_EX_MemRead = 1'b0; bus.EX_Redirect = 1'b0;
      #2 chk("after_redirect", {24'd0, outs}, {24'd0, O_DEF});

      // 3 wait states with redirect held; honoured only when ready arrives
      tick();
      bus.EX_MEM_MemRead = 1'b1; bus.dmem_ready = 1'b0; bus.EX_Redirect = 1'b1;
      #2 chk("wait3_frz1", {24'd0, outs}, {24'd0, O_FRZ});
      tick();
      #2 chk("wait3_frz2", {24'd0, outs}, {24'd0, O_FRZ});
      tick();
      #2 chk("wait3_frz3", {24'd0, outs}, {24'd0, O_FRZ});
      tick();
      bus.dmem_ready = 1'b1;
      #2 chk("wait3_release_redirect", {24'd0, outs}, {24'd0, O_MEMRD});
      tick();
      bus.EX_MEM_MemRead = 1'b0; bus.dmem_ready = 1'b0; bus.EX_Redirect = 1'b0;
      #2 chk("wait3_back_to_run", {24'd0, outs}, {24'd0, O_DEF});
`ifdef PIPE_PERF_EN
      // stalls: 2 load-use + 3 frozen; flushes: 1 + 1 redirect
      chk("perf_stall_count", bus.stall_cnt, 32'd5);
      chk("perf_flush_count", bus.flush_cnt, 32'd2);
`endif

      // zero-wait store adds no stall
      tick();
      bus.EX_MEM_MemWrite = 1'b1; bus.dmem_ready = 1'b1;
      #2 chk("zero_wait_store", {24'd0, outs}, {24'd0, O_MEMOK});
      tick();
      bus.EX_MEM_MemWrite = 1'b0; bus.dmem_ready = 1'b0;
      #2 chk("zero_wait_after", {24'd0, outs}, {24'd0, O_DEF});

      // timeout: 4 frozen cycles, then TRAP
      tick();
      bus.EX_MEM_MemRead = 1'b1;
      #2 chk("to_frz1", {24'd0, outs}, {24'd0, O_FRZ});
      tick();
      #2 chk("to_frz2", {24'd0, outs}, {24'd0, O_FRZ});
      tick();
      #2 chk("to_frz3", {24'd0, outs}, {24'd0, O_FRZ});
      tick();
      #2 chk("to_frz4", {24'd0, outs}, {24'd0, O_FRZ});
      tick();
      #2 chk("to_trap", {24'd0, outs}, {24'd0, O_TRAP});
      tick();
      bus.dmem_ready = 1'b1; bus.EX_Redirect = 1'b1;
      #2 chk("trap_ignores_ready", {24'd0, outs}, {24'd0, O_TRAP});
      tick();
      bus.EX_MEM_MemRead = 1'b0; bus.dmem_ready = 1'b0; bus.EX_Redirect = 1'b0;
      #2 chk("trap_sticky", {24'd0, outs}, {24'd0, O_TRAP});

      // async reset out of TRAP, between clock edges
      #1 reset = 1'b1;
      #1 chk("async_reset_trap", {24'd0, outs}, {24'd0, O_RST});
      tick();
      reset = 1'b0;
      #2 chk("run_after_trap_reset", {24'd0, outs}, {24'd0, O_DEF});

      // enter MEM_WAIT, then async reset mid-wait
      tick();
      bus.EX_MEM_MemRead = 1'b1;
      #2 chk("mw_frz1", {24'd0, outs}, {24'd0, O_FRZ});
      tick();
      #2 chk("mw_frz2", {24'd0, outs}, {24'd0, O_FRZ});
      tick();
      #2 chk("mw_frz3", {24'd0, outs}, {24'd0, O_FRZ});
      #1 reset = 1'b1;
      #1 chk("async_reset_mem_wait", {24'd0, outs}, {24'd0, O_RST});
      reset = 1'b0;
      // a fresh RUN with a cleared wait count needs four more stalled cycles
      #1 chk("rel_frz1", {24'd0, outs}, {24'd0, O_FRZ});
`ifdef PIPE_PERF_EN
      chk("perf_stall_cleared", bus.stall_cnt, 32'd0);
      chk("perf_flush_cleared", bus.flush_cnt, 32'd0);
`endif
      tick();
      #2 chk("rel_frz2", {24'd0, outs}, {24'd0, O_FRZ});
      tick();
      #2 chk("rel_frz3", {24'd0, outs}, {24'd0, O_FRZ});
      tick();
      #2 chk("rel_frz4", {24'd0, outs}, {24'd0, O_FRZ});
      tick();
      #2 chk("rel_trap", {24'd0, outs}, {24'd0, O_TRAP});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
